// File: rtl/serial_deserializer_if.sv
// Bundles the serial input stream and the parallel word output of serial_deserializer.
// The master modport drives the bit stream and the ready signal. The slave modport is the deserializer side.
interface serial_deserializer_if;
  logic       serial_in;
  logic       serial_valid;
  logic       frame_start;
  logic       msb_first;
  logic       data_ready;
  logic [7:0] data_out;
  logic       data_valid;
  logic       busy;
  logic       overrun;
  logic       frame_err;
  logic       parity_err;

  modport master (
    output serial_in, serial_valid, frame_start, msb_first, data_ready,
    input  data_out, data_valid, busy, overrun, frame_err, parity_err
  );

  modport slave (
    input  serial_in, serial_valid, frame_start, msb_first, data_ready,
    output data_out, data_valid, busy, overrun, frame_err, parity_err
  );
endinterface

// File: rtl/serial_deserializer.sv
// Assembles 8-bit words from a strobed serial stream into a held output register.
// Optional even-parity bit per word is enabled by defining SERIAL_DESERIALIZER_PARITY_EN.
module serial_deserializer (
  input  logic                   clk,
  input  logic                   reset,
  serial_deserializer_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT
`ifdef SERIAL_DESERIALIZER_PARITY_EN
    , PARITY
`endif
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  count_q, count_d;
  logic [7:0]  shift_q, shift_d;
  logic        msb_q, msb_d;
  logic [7:0]  data_out_q, data_out_d;
  logic        data_valid_q, data_valid_d;
  logic        overrun_q, overrun_d;
  logic        frame_err_q, frame_err_d;
  logic        parity_err_q, parity_err_d;

  logic [7:0]  shifted;
  logic [7:0]  word;
  logic        word_perr;
  logic        complete;

  assign shifted = msb_q ? {shift_q[6:0], bus.serial_in} : {bus.serial_in, shift_q[7:1]};

  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    shift_d      = shift_q;
    msb_d        = msb_q;
    data_out_d   = data_out_q;
    data_valid_d = data_valid_q;
    parity_err_d = parity_err_q;
    overrun_d    = 1'b0;
    frame_err_d  = 1'b0;
    complete     = 1'b0;
    word         = shifted;
    word_perr    = 1'b0;

    if (bus.serial_valid) begin
      if (bus.frame_start) begin
        // A start beat always restarts the frame; only a partial word counts as an abort.
        frame_err_d = (state_q != IDLE);
        state_d     = SHIFT;
        count_d     = 4'd1;
        msb_d       = bus.msb_first;
        shift_d     = bus.msb_first ? {7'b0, bus.serial_in} : {bus.serial_in, 7'b0};
      end else begin
        case (state_q)
          IDLE: ;
          SHIFT: begin
            shift_d = shifted;
            count_d = count_q + 4'd1;
            if (count_q == 4'd7) begin
`ifdef SERIAL_DESERIALIZER_PARITY_EN
              state_d = PARITY;
`else
              state_d  = IDLE;
              complete = 1'b1;
`endif
            end
          end
`ifdef SERIAL_DESERIALIZER_PARITY_EN
          PARITY: begin
            state_d   = IDLE;
            count_d   = '0;
            complete  = 1'b1;
            word      = shift_q;
            word_perr = ^{shift_q, bus.serial_in};
          end
`endif
          default: state_d = IDLE;
        endcase
      end
    end

    if (complete) begin
      if (data_valid_q && !bus.data_ready) begin
        overrun_d = 1'b1;
      end else begin
        data_out_d   = word;
        data_valid_d = 1'b1;
        parity_err_d = word_perr;
      end
    end else if (data_valid_q && bus.data_ready) begin
      data_valid_d = 1'b0;
      parity_err_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      count_q      <= '0;
      shift_q      <= '0;
      msb_q        <= 1'b0;
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
      overrun_q    <= 1'b0;
      frame_err_q  <= 1'b0;
      parity_err_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      shift_q      <= shift_d;
      msb_q        <= msb_d;
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
      overrun_q    <= overrun_d;
      frame_err_q  <= frame_err_d;
      parity_err_q <= parity_err_d;
    end
  end

  assign bus.data_out   = data_out_q;
  assign bus.data_valid = data_valid_q;
  assign bus.busy       = (state_q != IDLE);
  assign bus.overrun    = overrun_q;
  assign bus.frame_err  = frame_err_q;
  assign bus.parity_err = parity_err_q;

endmodule
